// File: rtl/memrq_arbiter.sv
// -----------------------------------------------------------------------------
// memrq_arbiter
//
// Shares one memrq2axi request port between two requesters:
//    p0 = data side (load/store), p1 = instruction fetch.
// Each requester's one-cycle request pulse is captured into a per-port
// buffer. When the downstream port is idle, one pending request is granted
// and forwarded as a one-cycle m_request_enable pulse. The grant is held
// until m_response_enable. The response is then routed back to the owning
// port. Only one transaction is ever outstanding downstream.
//
// Configuration macro: MEMARB_RR_EN
//    defined   : if both ports are pending, the port that did not win last
//                time is granted (round robin).
//    undefined : fixed priority, p0 always wins.
//    In both builds a single pending port is granted immediately.
//
// Ports
//    clk, rstn                    clock, synchronous active-low reset
//    pN_request_enable            request pulse; the pN_req_* fields are
//                                 sampled in the same cycle
//    pN_req_mode/addr/wdata/wstrb request fields (mode passed through as-is)
//    pN_response_enable           one-cycle response pulse to port N
//    pN_resp_data                 response data; holds between responses
//    pN_busy                      port N has a request pending or in flight
//    m_request_enable             one-cycle request pulse to memrq2axi
//    m_req_mode/addr/wdata/wstrb  granted request fields; stable until the
//                                 next grant
//    m_response_enable            response pulse from memrq2axi
//    m_resp_data                  response data from memrq2axi
//    err_overrun                  sticky: a request arrived on a busy port
// -----------------------------------------------------------------------------
module memrq_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                p0_request_enable,
   input  logic                p0_req_mode,
   input  logic [ADDR_W-1:0]   p0_req_addr,
   input  logic [DATA_W-1:0]   p0_req_wdata,
   input  logic [DATA_W/8-1:0] p0_req_wstrb,
   output logic                p0_response_enable,
   output logic [DATA_W-1:0]   p0_resp_data,
   output logic                p0_busy,
   input  logic                p1_request_enable,
   input  logic                p1_req_mode,
   input  logic [ADDR_W-1:0]   p1_req_addr,
   input  logic [DATA_W-1:0]   p1_req_wdata,
   input  logic [DATA_W/8-1:0] p1_req_wstrb,
   output logic                p1_response_enable,
   output logic [DATA_W-1:0]   p1_resp_data,
   output logic                p1_busy,
   output logic                m_request_enable,
   output logic                m_req_mode,
   output logic [ADDR_W-1:0]   m_req_addr,
   output logic [DATA_W-1:0]   m_req_wdata,
   output logic [DATA_W/8-1:0] m_req_wstrb,
   input  logic                m_response_enable,
   input  logic [DATA_W-1:0]   m_resp_data,
   output logic                err_overrun
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [1:0]          pend_q;      // request captured, not yet issued
   logic [1:0]          busy_q;      // pending or in flight
   logic [1:0]          resp_en_q;
   logic                owner_q;     // port currently granted (0 = p0)
   logic                err_q;

   // per-port request buffers
   logic                p0_mode_q;
   logic [ADDR_W-1:0]   p0_addr_q;
   logic [DATA_W-1:0]   p0_wdata_q;
   logic [STRB_W-1:0]   p0_wstrb_q;
   logic                p1_mode_q;
   logic [ADDR_W-1:0]   p1_addr_q;
   logic [DATA_W-1:0]   p1_wdata_q;
   logic [STRB_W-1:0]   p1_wstrb_q;

   // downstream request and upstream response registers
   logic                m_req_en_q;
   logic                m_mode_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [DATA_W-1:0]   m_wdata_q;
   logic [STRB_W-1:0]   m_wstrb_q;
   logic [DATA_W-1:0]   p0_rdata_q;
   logic [DATA_W-1:0]   p1_rdata_q;

`ifdef MEMARB_RR_EN
   logic                last_grant_q;
`endif

   logic [1:0]          cap_s;
   logic                ovr_s;
   logic                grant_vld_s;
   logic                grant_sel_s;

   // Capture/overrun detection and grant selection from the pending set.
   always_comb begin
      cap_s       = 2'b00;
      ovr_s       = 1'b0;
      grant_vld_s = 1'b0;
      grant_sel_s = 1'b0;
      // A request is only accepted on a port that is not already busy;
      // this keeps the latched fields stable while a transaction is open.
      cap_s[0] = p0_request_enable & ~busy_q[0];
      cap_s[1] = p1_request_enable & ~busy_q[1];
      ovr_s    = (p0_request_enable & busy_q[0]) | (p1_request_enable & busy_q[1]);
      grant_vld_s = pend_q[0] | pend_q[1];
`ifdef MEMARB_RR_EN
      if (pend_q == 2'b11) begin
         grant_sel_s = ~last_grant_q;
      end else begin
         grant_sel_s = ~pend_q[0];
      end
`else
      grant_sel_s = ~pend_q[0];
`endif
   end

   // Arbiter FSM with request capture, forwarding and response routing.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         pend_q     <= 2'b00;
         busy_q     <= 2'b00;
         resp_en_q  <= 2'b00;
         owner_q    <= 1'b0;
         err_q      <= 1'b0;
         p0_mode_q  <= 1'b0;
         p0_addr_q  <= '0;
         p0_wdata_q <= '0;
         p0_wstrb_q <= '0;
         p1_mode_q  <= 1'b0;
         p1_addr_q  <= '0;
         p1_wdata_q <= '0;
         p1_wstrb_q <= '0;
         m_req_en_q <= 1'b0;
         m_mode_q   <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         m_wstrb_q  <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
`ifdef MEMARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         resp_en_q <= 2'b00;
         if (ovr_s) begin
            err_q <= 1'b1;
         end
         if (cap_s[0]) begin
            pend_q[0]  <= 1'b1;
            busy_q[0]  <= 1'b1;
            p0_mode_q  <= p0_req_mode;
            p0_addr_q  <= p0_req_addr;
            p0_wdata_q <= p0_req_wdata;
            p0_wstrb_q <= p0_req_wstrb;
         end
         if (cap_s[1]) begin
            pend_q[1]  <= 1'b1;
            busy_q[1]  <= 1'b1;
            p1_mode_q  <= p1_req_mode;
            p1_addr_q  <= p1_req_addr;
            p1_wdata_q <= p1_req_wdata;
            p1_wstrb_q <= p1_req_wstrb;
         end
         case (state_q)
            ST_IDLE: begin
               if (grant_vld_s) begin
                  m_req_en_q <= 1'b1;
                  owner_q    <= grant_sel_s;
                  if (grant_sel_s) begin
                     m_mode_q  <= p1_mode_q;
                     m_addr_q  <= p1_addr_q;
                     m_wdata_q <= p1_wdata_q;
                     m_wstrb_q <= p1_wstrb_q;
                  end else begin
                     m_mode_q  <= p0_mode_q;
                     m_addr_q  <= p0_addr_q;
                     m_wdata_q <= p0_wdata_q;
                     m_wstrb_q <= p0_wstrb_q;
                  end
`ifdef MEMARB_RR_EN
                  last_grant_q <= grant_sel_s;
`endif
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // The winner's port is still busy, so no capture can race
               // with this clear.
               m_req_en_q      <= 1'b0;
               pend_q[owner_q] <= 1'b0;
               state_q         <= ST_WAIT;
            end
            ST_WAIT: begin
               if (m_response_enable) begin
                  resp_en_q[owner_q] <= 1'b1;
                  busy_q[owner_q]    <= 1'b0;
                  if (owner_q) begin
                     p1_rdata_q <= m_resp_data;
                  end else begin
                     p0_rdata_q <= m_resp_data;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               m_req_en_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign p0_response_enable = resp_en_q[0];
   assign p1_response_enable = resp_en_q[1];
   assign p0_resp_data       = p0_rdata_q;
   assign p1_resp_data       = p1_rdata_q;
   assign p0_busy            = busy_q[0];
   assign p1_busy            = busy_q[1];
   assign m_request_enable   = m_req_en_q;
   assign m_req_mode         = m_mode_q;
   assign m_req_addr         = m_addr_q;
   assign m_req_wdata        = m_wdata_q;
   assign m_req_wstrb        = m_wstrb_q;
   assign err_overrun        = err_q;

endmodule
